// File: rtl/msrv32_pc_skid_reg.sv
// Fetch-PC pipeline register with a two-entry skid buffer, flush/redirect and optional stall counter.
// Latency: in_data -> out_data is 1 cycle when main is empty or being consumed; flush target shows 1 cycle later.
// Backpressure: in_ready = !skid_valid (registered); absorbs a one-cycle out_ready drop. Counter built with MSRV32_PC_STALL_CNT_EN.
module msrv32_pc_skid_reg #(
  parameter int             WIDTH        = 32,
  parameter logic [WIDTH-1:0] BOOT_ADDRESS = '0,
  parameter bit             RESET_VALID  = 1'b1
) (
  input  logic             clock,
  input  logic             rst_in,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic             flush_in,
  input  logic [WIDTH-1:0] flush_data,
  output logic [31:0]      stall_count_out
);

  logic             main_valid;
  logic [WIDTH-1:0] main_data;
  logic             skid_valid;
  logic [WIDTH-1:0] skid_data;
  logic             accept;
  logic             main_free;

  // Ready depends only on registered state, so no comb path from out_ready/in_valid.
  assign in_ready  = !skid_valid;
  assign accept    = in_valid && in_ready;
  // Main can take a new word when it is empty or being drained this cycle.
  assign main_free = !main_valid || out_ready;

  assign out_valid = main_valid;
  assign out_data  = main_data;

  // Slot update: reset, then flush redirect, then in-order main/skid transfers.
  always_ff @(posedge clock) begin
    if (rst_in) begin
      main_data  <= BOOT_ADDRESS;
      main_valid <= RESET_VALID;
      skid_valid <= 1'b0;
      skid_data  <= '0;
    end else if (flush_in) begin
      // Redirect wins; any word accepted this cycle is deliberately dropped.
      main_data  <= flush_data;
      main_valid <= 1'b1;
      skid_valid <= 1'b0;
    end else if (main_free) begin
      if (skid_valid) begin
        // Drain the older skid word first to keep arrival order.
        main_data  <= skid_data;
        main_valid <= 1'b1;
        skid_valid <= 1'b0;
      end else if (accept) begin
        main_data  <= in_data;
        main_valid <= 1'b1;
      end else begin
        main_valid <= 1'b0;
      end
    end else if (accept) begin
      skid_data  <= in_data;
      skid_valid <= 1'b1;
    end
  end

`ifdef MSRV32_PC_STALL_CNT_EN
  logic [31:0] stall_cnt;
  logic [31:0] stall_nxt;

  // Count cycles where a valid PC is held back by downstream; saturate at all-ones.
  always_comb begin
    stall_nxt = stall_cnt;
    if (main_valid && !out_ready && !flush_in && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_nxt = stall_cnt + 32'd1;
    end
  end

  // Counter register; written every cycle so its value always tracks stall_nxt.
  always_ff @(posedge clock) begin
    if (rst_in) begin
      stall_cnt <= 32'd0;
    end else begin
      stall_cnt <= stall_nxt;
    end
  end

  assign stall_count_out = stall_cnt;
`else
  assign stall_count_out = 32'h0;
`endif

endmodule

// File: tb/tb_msrv32_pc_skid_reg.sv
// Directed bench for msrv32_pc_skid_reg: reset, streaming, single stall, flush, reset mid-stall, saturation.
// Inputs are driven 1 time unit after the rising edge, outputs sampled at the same point.
// Works with MSRV32_PC_STALL_CNT_EN defined or undefined.
module tb_msrv32_pc_skid_reg;

  logic        clock = 1'b0;
  logic        rst_in;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        flush_in;
  logic [31:0] flush_data;
  logic [31:0] stall_count_out;

  int checks   = 0;
  int failures = 0;

`ifdef MSRV32_PC_STALL_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  msrv32_pc_skid_reg #(
    .WIDTH(32),
    .BOOT_ADDRESS(32'h0000_1000),
    .RESET_VALID(1'b1)
  ) dut (
    .clock(clock),
    .rst_in(rst_in),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .flush_in(flush_in),
    .flush_data(flush_data),
    .stall_count_out(stall_count_out)
  );

  always #5 clock = ~clock;

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] cnt_exp(input logic [31:0] v);
    return CNT_EN ? v : 32'h0;
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    rst_in = 1'b1; in_valid = 1'b0; in_data = 32'h0; out_ready = 1'b1;
    flush_in = 1'b0; flush_data = 32'h0;

    // Reset
    step();
    chk32("rst_out_data", out_data, 32'h0000_1000);
    chk1 ("rst_out_valid", out_valid, 1'b1);
    chk1 ("rst_in_ready", in_ready, 1'b1);
    chk32("rst_stall_cnt", stall_count_out, 32'h0);

    // Streaming with out_ready high
    rst_in = 1'b0; in_valid = 1'b1; in_data = 32'h4;
    step();
    chk32("stream_4", out_data, 32'h4);
    chk1 ("stream_4_rdy", in_ready, 1'b1);
    in_data = 32'h8;
    step();
    chk32("stream_8", out_data, 32'h8);
    chk1 ("stream_8_rdy", in_ready, 1'b1);
    in_data = 32'hC;
    step();
    chk32("stream_c", out_data, 32'hC);
    chk1 ("stream_c_vld", out_valid, 1'b1);
    chk1 ("stream_c_rdy", in_ready, 1'b1);

    // Single-cycle stall: 0x10 goes to the skid
    in_data = 32'h10; out_ready = 1'b0;
    step();
    chk32("stall_hold_c", out_data, 32'hC);
    chk1 ("stall_in_ready", in_ready, 1'b0);
    chk32("stall_cnt_1", stall_count_out, cnt_exp(32'd1));
    // Resume; upstream keeps 0x14 offered but it is not accepted yet
    out_ready = 1'b1; in_data = 32'h14;
    step();
    chk32("resume_10", out_data, 32'h10);
    chk1 ("resume_in_ready", in_ready, 1'b1);
    step();
    chk32("resume_14", out_data, 32'h14);

    // Fill both slots (main=0x14, skid=0x24)
    out_ready = 1'b0; in_data = 32'h24;
    step();
    chk32("fill_main", out_data, 32'h14);
    chk1 ("fill_in_ready", in_ready, 1'b0);
    chk32("fill_cnt_2", stall_count_out, cnt_exp(32'd2));

    // Flush with accept offered: 0x18 and 0x24 are both dropped
    flush_in = 1'b1; flush_data = 32'h2000; in_data = 32'h18;
    step();
    chk32("flush_data", out_data, 32'h2000);
    chk1 ("flush_valid", out_valid, 1'b1);
    chk1 ("flush_in_ready", in_ready, 1'b1);
    chk32("flush_cnt_kept", stall_count_out, cnt_exp(32'd2));
    flush_in = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    step();
    chk1 ("post_flush_empty", out_valid, 1'b0);
    chk1 ("post_flush_rdy", in_ready, 1'b1);

    // Reset mid-stall with skid full
    in_valid = 1'b1; in_data = 32'h30; out_ready = 1'b0;
    step();
    chk32("refill_30", out_data, 32'h30);
    in_data = 32'h34;
    step();
    chk1 ("refill_skid_full", in_ready, 1'b0);
    chk32("refill_cnt_3", stall_count_out, cnt_exp(32'd3));
    rst_in = 1'b1;
    step();
    chk32("midrst_out_data", out_data, 32'h0000_1000);
    chk1 ("midrst_valid", out_valid, 1'b1);
    chk1 ("midrst_in_ready", in_ready, 1'b1);
    chk32("midrst_cnt", stall_count_out, 32'h0);
    rst_in = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    step();
    chk1 ("midrst_skid_dropped", out_valid, 1'b0);

    // Saturation: preload near the top, then stall 3 cycles
    in_valid = 1'b1; in_data = 32'h44; out_ready = 1'b1;
`ifdef MSRV32_PC_STALL_CNT_EN
    force dut.stall_cnt = 32'hFFFF_FFFE;
`endif
    step();
`ifdef MSRV32_PC_STALL_CNT_EN
    release dut.stall_cnt;
`endif
    chk32("sat_load_44", out_data, 32'h44);
    chk32("sat_preload", stall_count_out, cnt_exp(32'hFFFF_FFFE));
    in_valid = 1'b0; out_ready = 1'b0;
    step();
    chk32("sat_1", stall_count_out, cnt_exp(32'hFFFF_FFFF));
    step();
    chk32("sat_2", stall_count_out, cnt_exp(32'hFFFF_FFFF));
    step();
    chk32("sat_3", stall_count_out, cnt_exp(32'hFFFF_FFFF));
    chk32("sat_hold_44", out_data, 32'h44);
    chk1 ("sat_valid", out_valid, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
